// File: rtl/bcd_score_accumulator.sv
// Serial BCD score accumulator: adds a packed BCD increment to the running
// score one digit per cycle through a single shared one-digit BCD adder.

module bcdadd1 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] bin;
  logic [4:0] adj;

  // Operands are guaranteed BCD (<=9), so the binary sum never exceeds 19.
  always_comb begin
    bin  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    adj  = bin + 5'd6;
    cout = (bin > 5'd9);
    s    = cout ? adj[3:0] : bin[3:0];
  end
endmodule

module bcd_score_accumulator #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  add_valid,
  input  logic [4*DIGITS-1:0]   add_value,
  output logic                  add_ready,
  output logic [4*DIGITS-1:0]   score,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t                 state;
  logic [DIGITS-1:0][3:0] score_q;
  logic [DIGITS-1:0][3:0] opnd;
  logic [DIGITS-1:0][3:0] work;
  logic [DIGITS-1:0][3:0] work_nxt;
  logic [DIGITS-1:0][3:0] add_in;
  logic [DIGITS-1:0][3:0] clamped;
  logic                   carry;
  logic [IW-1:0]          idx;
  logic                   last;
  logic [3:0]             dsum;
  logic                   dcout;

  assign add_in = add_value;

  // Non-BCD increment digits are saturated to 9 so the adder only sees BCD.
  always_comb begin
    clamped = '0;
    for (int i = 0; i < DIGITS; i++)
      clamped[i] = (add_in[i] > 4'd9) ? 4'd9 : add_in[i];
  end

  bcdadd1 u_add (
    .a    (work[idx]),
    .b    (opnd[idx]),
    .cin  (carry),
    .s    (dsum),
    .cout (dcout)
  );

  always_comb begin
    work_nxt      = work;
    work_nxt[idx] = dsum;
  end

  assign last = (idx == IW'(DIGITS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      score_q  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      opnd     <= '0;
      work     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
    end else if (clear) begin
      // Abort any in-flight addition without a done pulse.
      state    <= IDLE;
      score_q  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (add_valid) begin
            opnd  <= clamped;
            work  <= score_q;
            carry <= 1'b0;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          work  <= work_nxt;
          carry <= dcout;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            // Commit uses the just-computed top digit; a final carry saturates.
            state <= DONE;
            done  <= 1'b1;
            if (dcout) begin
              score_q  <= {DIGITS{4'h9}};
              overflow <= 1'b1;
            end else begin
              score_q  <= work_nxt;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign score     = score_q;
  assign busy      = (state != IDLE);
  assign add_ready = (state == IDLE);
endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Directed bench for bcd_score_accumulator (DIGITS=4): table of chained
// additions plus hand sequences for clear-abort and asynchronous reset.

module tb_bcd_score_accumulator;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                clear;
  logic                add_valid;
  logic [4*DIGITS-1:0] add_value;
  logic                add_ready;
  logic [4*DIGITS-1:0] score;
  logic                busy;
  logic                done;
  logic                overflow;

  int nchk = 0;
  int nerr = 0;
  int ndone = 0;
  int exp_done = 0;

  bcd_score_accumulator #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .add_valid (add_valid),
    .add_value (add_value),
    .add_ready (add_ready),
    .score     (score),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && done) ndone++;

  typedef struct {
    logic        clr;
    logic [15:0] val;
    logic [15:0] exp_s;
    logic        exp_o;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clear_score", score, 0);
    check("clear_ovf", overflow, 0);
    check("clear_ready", add_ready, 1);
  endtask

  task automatic do_add(input logic [15:0] v, input logic [15:0] es, input logic eo);
    logic [15:0] old;
    int n;
    @(negedge clk);
    n = 0;
    while (!add_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_before", add_ready, 1);
    old = score;
    add_valid = 1'b1;
    add_value = v;
    @(posedge clk); #1;
    add_valid = 1'b0;
    check("accept_ready", add_ready, 0);
    check("accept_busy", busy, 1);
    n = 0;
    while (!done && n < 20) begin
      check("score_hold", score, old);
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, DIGITS);
    check("score", score, es);
    check("ovf", overflow, eo);
    check("done_busy", busy, 1);
    exp_done++;
    @(posedge clk); #1;
    check("done_drop", done, 0);
    check("ready_back", add_ready, 1);
    check("busy_drop", busy, 0);
  endtask

  initial begin
    int n;
    tbl[0]  = '{1'b1, 16'h0001, 16'h0001, 1'b0};
    tbl[1]  = '{1'b1, 16'h0999, 16'h0999, 1'b0};
    tbl[2]  = '{1'b0, 16'h0001, 16'h1000, 1'b0};
    tbl[3]  = '{1'b1, 16'h9998, 16'h9998, 1'b0};
    tbl[4]  = '{1'b0, 16'h0005, 16'h9999, 1'b1};
    tbl[5]  = '{1'b0, 16'h0001, 16'h9999, 1'b1};
    tbl[6]  = '{1'b1, 16'h00A3, 16'h0093, 1'b0};
    tbl[7]  = '{1'b0, 16'h1234, 16'h1327, 1'b0};
    tbl[8]  = '{1'b0, 16'hFFFF, 16'h9999, 1'b1};
    tbl[9]  = '{1'b1, 16'h4567, 16'h4567, 1'b0};
    tbl[10] = '{1'b0, 16'h5433, 16'h9999, 1'b1};
    tbl[11] = '{1'b1, 16'h0000, 16'h0000, 1'b0};

    rst = 1'b1;
    clear = 1'b0;
    add_valid = 1'b0;
    add_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_score", score, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", add_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].clr) do_clear();
      do_add(tbl[i].val, tbl[i].exp_s, tbl[i].exp_o);
    end

    // Clear two cycles after accept aborts; add_valid held with clear waits.
    do_clear();
    do_add(16'h1234, 16'h1234, 1'b0);
    @(negedge clk);
    add_valid = 1'b1;
    add_value = 16'h0500;
    @(posedge clk); #1;
    add_valid = 1'b0;
    check("abort_accept", add_ready, 0);
    @(posedge clk); #1;
    check("abort_hold", score, 16'h1234);
    @(negedge clk);
    clear = 1'b1;
    add_valid = 1'b1;
    add_value = 16'h0007;
    @(posedge clk); #1;
    check("abort_score", score, 0);
    check("abort_ovf", overflow, 0);
    check("abort_ready", add_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(posedge clk); #1;
    check("clr_blocks_accept", add_ready, 1);
    clear = 1'b0;
    @(posedge clk); #1;
    add_valid = 1'b0;
    check("held_accept", add_ready, 0);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_latency", n, DIGITS);
    check("held_score", score, 16'h0007);
    exp_done++;

    // Asynchronous reset in the middle of a saturating sequence.
    do_clear();
    do_add(16'h9999, 16'h9999, 1'b0);
    do_add(16'h0001, 16'h9999, 1'b1);
    @(negedge clk);
    add_valid = 1'b1;
    add_value = 16'h0002;
    @(posedge clk); #1;
    add_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_score", score, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", add_ready, 1);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    do_add(16'h0042, 16'h0042, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", ndone, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
